// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: branch type encodings and program counter defaults.
package kgp_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int PC_STEP_DEF = 1;

  typedef enum logic [2:0] {
    BR_B    = 3'd0,
    BR_BR   = 3'd1,
    BR_BLTZ = 3'd2,
    BR_BZ   = 3'd3,
    BR_BNZ  = 3'd4,
    BR_BL   = 3'd5,
    BR_BCY  = 3'd6,
    BR_BNCY = 3'd7
  } br_type_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator for the eight KGP-RISC branch types.
module branch_cond
  import kgp_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       neg,
  input  logic       carry_q,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_B, BR_BR, BR_BL: cond = 1'b1;
      BR_BLTZ:            cond = neg;
      BR_BZ:              cond = zero;
      BR_BNZ:             cond = ~zero;
      BR_BCY:             cond = carry_q;
      BR_BNCY:            cond = ~carry_q;
      default:            cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Execute-stage branch resolution: flag register, branch decision, PC update,
// BL link write and a one-cycle flush after every taken branch.
module branch_pc_unit
  import kgp_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int PC_STEP = PC_STEP_DEF,
  parameter int OFF_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flag_we,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             zero_in,
  input  logic             neg_in,
  input  logic             br_en,
  input  logic [2:0]       br_type,
  input  logic [OFF_W-1:0] br_off,
  input  logic [PC_W-1:0]  rs_val,
  output logic [PC_W-1:0]  pc,
  output logic             taken,
  output logic             flush,
  output logic             link_we,
  output logic [PC_W-1:0]  link_val,
  output logic             carry_q,
  output logic             ovf_q
);

  logic                   cond;
  logic                   vld_p0;
  logic signed [PC_W-1:0] off_sext;
  logic [PC_W-1:0]        target;
  logic [PC_W-1:0]        pc_nxt;

  branch_cond u_cond (
    .br_type (br_type),
    .zero    (zero_in),
    .neg     (neg_in),
    .carry_q (carry_q),
    .cond    (cond)
  );

  // A squashed (flushed) or stalled slot never resolves a branch.
  assign vld_p0   = br_en & ~flush & ~stall;
  assign taken    = vld_p0 & cond;
  assign link_we  = taken & (br_type == BR_BL);
  assign link_val = pc + PC_W'(PC_STEP);

  assign off_sext = PC_W'(signed'(br_off));
  assign target   = (br_type == BR_BR) ? rs_val : pc + PC_W'(off_sext);

  always_comb begin
    pc_nxt = link_val;
    if (stall)      pc_nxt = pc;
    else if (taken) pc_nxt = target;
  end

  // Stage boundary: decision in cycle N, new pc and flush visible in N+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= '0;
      flush   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!stall) begin
      pc    <= pc_nxt;
      flush <= taken;
      if (flag_we && !flush) begin
        carry_q <= carry_in;
        ovf_q   <= ovf_in;
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit.
module tb_branch_pc_unit;
  import kgp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flag_we, carry_in, ovf_in, zero_in, neg_in, br_en;
  logic [2:0]  br_type;
  logic [15:0] br_off;
  logic [31:0] rs_val;
  logic [31:0] pc, link_val;
  logic        taken, flush, link_we, carry_q, ovf_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we),
    .carry_in(carry_in), .ovf_in(ovf_in), .zero_in(zero_in), .neg_in(neg_in),
    .br_en(br_en), .br_type(br_type), .br_off(br_off), .rs_val(rs_val),
    .pc(pc), .taken(taken), .flush(flush), .link_we(link_we),
    .link_val(link_val), .carry_q(carry_q), .ovf_q(ovf_q)
  );

  task automatic idle();
    stall = 0; flag_we = 0; carry_in = 0; ovf_in = 0; zero_in = 0; neg_in = 0;
    br_en = 0; br_type = 3'd0; br_off = 16'd0; rs_val = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Jump to v-1 with BR, then let the flush cycle advance pc to v.
  task automatic set_pc(input logic [31:0] v);
    br_en = 1; br_type = BR_BR; rs_val = v - 32'd1;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #2;
    checks++; if (pc !== 32'd0)  begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush); end
    checks++; if ({carry_q, ovf_q} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {carry_q, ovf_q}); end
    @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 32'(i)) begin errors++; $display("FAIL seq_pc%0d got %h want %h", i, pc, 32'(i)); end
    end
    br_en = 1; br_type = BR_BR; rs_val = 32'h40;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL br_taken got %b want 1", taken); end
    tick();
    idle();
    checks++; if (pc !== 32'h40 || flush !== 1'b1) begin errors++; $display("FAIL br_pc_flush got %h/%b want 40/1", pc, flush); end
    rst = 0;
    #1;
    checks++; if (pc !== 32'd0 || flush !== 1'b0) begin errors++; $display("FAIL async_rst got %h/%b want 0/0", pc, flush); end
    #2;
    rst = 1;
    tick();
    checks++; if (pc !== 32'd1 || flush !== 1'b0) begin errors++; $display("FAIL post_rst got %h/%b want 1/0", pc, flush); end
  endtask

  task automatic test_bz_flush();
    set_pc(32'd10);
    checks++; if (pc !== 32'd10) begin errors++; $display("FAIL setpc10 got %h want a", pc); end
    br_en = 1; br_type = BR_BZ; br_off = 16'hFFFC; zero_in = 1;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bz_taken got %b want 1", taken); end
    tick();
    idle();
    checks++; if (pc !== 32'd6 || flush !== 1'b1) begin errors++; $display("FAIL bz_pc got %h/%b want 6/1", pc, flush); end
    br_en = 1; br_type = BR_B; br_off = 16'd100;
    #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL squash_taken got %b want 0", taken); end
    tick();
    idle();
    checks++; if (pc !== 32'd7 || flush !== 1'b0) begin errors++; $display("FAIL squash_pc got %h/%b want 7/0", pc, flush); end
  endtask

  task automatic test_carry();
    flag_we = 1; carry_in = 1; ovf_in = 1; br_en = 1; br_type = BR_BCY; br_off = 16'd2;
    #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bcy_old got %b want 0", taken); end
    tick();
    idle();
    checks++; if ({carry_q, ovf_q} !== 2'b11 || pc !== 32'd8) begin errors++; $display("FAIL flag_cap got %b/%h want 11/8", {carry_q, ovf_q}, pc); end
    br_en = 1; br_type = BR_BNCY; br_off = 16'd2;
    #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bncy got %b want 0", taken); end
    br_type = BR_BCY;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bcy_new got %b want 1", taken); end
    tick();
    idle();
    checks++; if (pc !== 32'd10 || flush !== 1'b1) begin errors++; $display("FAIL bcy_pc got %h/%b want a/1", pc, flush); end
    flag_we = 1; carry_in = 0; ovf_in = 0;
    tick();
    idle();
    checks++; if ({carry_q, ovf_q} !== 2'b11 || pc !== 32'd11) begin errors++; $display("FAIL flag_squash got %b/%h want 11/b", {carry_q, ovf_q}, pc); end
  endtask

  task automatic test_bl();
    set_pc(32'd20);
    br_en = 1; br_type = BR_BL; br_off = 16'd5;
    #1;
    checks++; if (link_we !== 1'b1 || link_val !== 32'd21) begin errors++; $display("FAIL bl_link got %b/%h want 1/15", link_we, link_val); end
    tick();
    idle();
    checks++; if (pc !== 32'd25 || flush !== 1'b1) begin errors++; $display("FAIL bl_pc got %h/%b want 19/1", pc, flush); end
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL bl_link_off got %b want 0", link_we); end
    tick();
  endtask

  task automatic test_stall();
    br_en = 1; br_type = BR_BR; rs_val = 32'h100; stall = 1; flag_we = 1; carry_in = 0;
    #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL stall_taken got %b want 0", taken); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'd26 || carry_q !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %h/%b want 1a/1", i, pc, carry_q); end
    end
    stall = 0; flag_we = 0;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL unstall_taken got %b want 1", taken); end
    tick();
    idle();
    checks++; if (pc !== 32'h100 || flush !== 1'b1) begin errors++; $display("FAIL unstall_pc got %h/%b want 100/1", pc, flush); end
    stall = 1;
    tick();
    checks++; if (pc !== 32'h100 || flush !== 1'b1) begin errors++; $display("FAIL flush_hold got %h/%b want 100/1", pc, flush); end
    stall = 0;
    tick();
    checks++; if (pc !== 32'h101 || flush !== 1'b0) begin errors++; $display("FAIL flush_end got %h/%b want 101/0", pc, flush); end
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFE);
    br_en = 1; br_type = BR_B; br_off = 16'd3;
    tick();
    idle();
    checks++; if (pc !== 32'd1 || flush !== 1'b1) begin errors++; $display("FAIL wrap_pc got %h/%b want 1/1", pc, flush); end
    tick();
    br_en = 1; br_type = BR_BNZ; br_off = 16'd50; zero_in = 1;
    #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bnz_taken got %b want 0", taken); end
    tick();
    idle();
    checks++; if (pc !== 32'd3 || flush !== 1'b0) begin errors++; $display("FAIL bnz_pc got %h/%b want 3/0", pc, flush); end
    br_en = 1; br_type = BR_BLTZ; br_off = 16'hFFFF; neg_in = 1;
    tick();
    idle();
    checks++; if (pc !== 32'd2 || flush !== 1'b1) begin errors++; $display("FAIL bltz_pc got %h/%b want 2/1", pc, flush); end
  endtask

  initial begin
    test_reset();
    test_bz_flush();
    test_carry();
    test_bl();
    test_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
